// File: rtl/eth_tx_sched_if.sv
// Handshake bundle between the frame transmit sequencer, the TX FIFO and the MAC byte path.
// master = sequencer side, slave = FIFO/MAC/control side.
`timescale 1ns/1ps
interface eth_tx_sched_if #(
    parameter int CNT_W = 9
);
    logic             i_start;
    logic [CNT_W-1:0] i_word_count;
    logic             o_busy;
    logic             o_done;
    logic             i_fifo_empty;
    logic [31:0]      i_fifo_data;
    logic             o_fifo_rd;
    logic             o_tx_valid;
    logic [7:0]       o_tx_data;
    logic             o_tx_last;
    logic             i_tx_ready;

    modport master (
        input  i_start, i_word_count, i_fifo_empty, i_fifo_data, i_tx_ready,
        output o_busy, o_done, o_fifo_rd, o_tx_valid, o_tx_data, o_tx_last
    );

    modport slave (
        output i_start, i_word_count, i_fifo_empty, i_fifo_data, i_tx_ready,
        input  o_busy, o_done, o_fifo_rd, o_tx_valid, o_tx_data, o_tx_last
    );
endinterface

// File: rtl/eth_tx_sched.sv
// Frame transmit sequencer: pops FIFO words, emits bytes LSB first, pads short
// frames with zeros and holds off the next start for an inter-frame gap.
//
// state  | meaning
// IDLE   | waiting for a start; zero-length start only pulses done
// LOAD   | waiting for a FIFO word to fetch
// SEND   | presenting the bytes of the held word
// PAD    | presenting zero bytes up to the minimum frame length
// IFG    | inter-frame gap down-counter; done on terminal count
`timescale 1ns/1ps
module eth_tx_sched #(
    parameter int CNT_W      = 9,
    parameter int MIN_BYTES  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    eth_tx_sched_if.master     bus
);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam logic [IFG_W-1:0]   IFG_LOAD = IFG_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W+1:0]   MIN_B    = (CNT_W + 2)'(MIN_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_PAD, S_IFG} state_t;

    state_t             state, state_nxt;
    logic [31:0]        word_q;
    logic [1:0]         idx_q;
    logic [CNT_W-1:0]   words_left_q;
    logic [CNT_W+1:0]   byte_cnt_q;
    logic [IFG_W-1:0]   ifg_cnt_q;
    logic               zero_done_q;

    logic               tx_valid;
    logic               tx_accept;
    logic               last_word;
    logic               word_end;
    logic               start_frame;
    logic [CNT_W+1:0]   bytes_next;

    assign tx_accept   = tx_valid && bus.i_tx_ready;
    assign last_word   = (words_left_q == CNT_W'(1));
    assign word_end    = (state == S_SEND) && tx_accept && (idx_q == 2'd3);
    assign start_frame = (state == S_IDLE) && bus.i_start && (bus.i_word_count != '0);
    assign bytes_next  = byte_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_frame) state_nxt = S_LOAD;
            S_LOAD: if (!bus.i_fifo_empty) state_nxt = S_SEND;
            S_SEND: begin
                if (word_end) begin
                    if (!last_word) begin
                        state_nxt = bus.i_fifo_empty ? S_LOAD : S_SEND;
                    end else begin
                        state_nxt = (bytes_next < MIN_B) ? S_PAD : S_IFG;
                    end
                end
            end
            S_PAD:  if (tx_accept && bytes_next == MIN_B) state_nxt = S_IFG;
            S_IFG:  if (ifg_cnt_q == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid      = (state == S_SEND) || (state == S_PAD);
        bus.o_busy    = (state != S_IDLE);
        bus.o_done    = ((state == S_IFG) && (ifg_cnt_q == '0)) || zero_done_q;
        // The refill pop rides on the accept of byte 3 so consecutive words have no bubble.
        bus.o_fifo_rd = ((state == S_LOAD) && !bus.i_fifo_empty)
                      || (word_end && !last_word && !bus.i_fifo_empty);
        bus.o_tx_data = 8'h00;
        bus.o_tx_last = 1'b0;
        if (state == S_SEND) begin
            bus.o_tx_data = word_q[{idx_q, 3'b000} +: 8];
            bus.o_tx_last = (idx_q == 2'd3) && last_word && (bytes_next >= MIN_B);
        end else if (state == S_PAD) begin
            bus.o_tx_last = (bytes_next == MIN_B);
        end
        bus.o_tx_valid = tx_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q       <= '0;
            idx_q        <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            ifg_cnt_q    <= '0;
            zero_done_q  <= 1'b0;
        end else begin
            zero_done_q <= (state == S_IDLE) && bus.i_start && (bus.i_word_count == '0);
            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        words_left_q <= bus.i_word_count;
                        byte_cnt_q   <= '0;
                        idx_q        <= '0;
                    end
                end
                S_LOAD: begin
                    if (!bus.i_fifo_empty) begin
                        word_q <= bus.i_fifo_data;
                        idx_q  <= '0;
                    end
                end
                S_SEND: begin
                    if (tx_accept) begin
                        byte_cnt_q <= bytes_next;
                        idx_q      <= idx_q + 2'd1;
                    end
                    if (word_end && !last_word) begin
                        words_left_q <= words_left_q - 1'b1;
                        if (!bus.i_fifo_empty) word_q <= bus.i_fifo_data;
                    end
                    if (word_end && last_word && bytes_next >= MIN_B) ifg_cnt_q <= IFG_LOAD;
                end
                S_PAD: begin
                    if (tx_accept) begin
                        byte_cnt_q <= bytes_next;
                        if (bytes_next == MIN_B) ifg_cnt_q <= IFG_LOAD;
                    end
                end
                S_IFG: begin
                    if (ifg_cnt_q != '0) ifg_cnt_q <= ifg_cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: FIFO/MAC models around the DUT, frame byte streams
// predicted from word lists and compared per scenario.
`timescale 1ns/1ps
module tb_eth_tx_sched;
    localparam int CNT_W      = 9;
    localparam int MIN_BYTES  = 60;
    localparam int IFG_CYCLES = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_tx_sched_if #(.CNT_W(CNT_W)) bus();

    eth_tx_sched #(.CNT_W(CNT_W), .MIN_BYTES(MIN_BYTES), .IFG_CYCLES(IFG_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [7:0]  got_data[$];
    bit          got_last[$];
    logic [7:0]  exp_data[$];
    logic [31:0] t1_words[$];

    int  cyc = 0;
    bit  rdy_rand = 1'b0;
    int  first_rd_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
    int  done_cnt, rd_cnt, valid_cnt, stab_err, rd_empty_err;
    bit  hold_prev = 1'b0;
    logic [7:0] prev_data;
    bit  prev_last;
    bit  rd_s;

    // Observe at the falling edge, commit FIFO pops and new ready just after the rising edge.
    always begin
        @(negedge clk);
        rd_s = 1'b0;
        if (rst_n) begin
            rd_s = bus.o_fifo_rd;
            if (bus.o_fifo_rd) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (fifo_q.size() == 0) rd_empty_err++;
            end
            if (bus.o_tx_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (hold_prev && (!bus.o_tx_valid || bus.o_tx_data !== prev_data || bus.o_tx_last !== prev_last))
                stab_err++;
            hold_prev = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data = bus.o_tx_data;
            prev_last = bus.o_tx_last;
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                got_data.push_back(bus.o_tx_data);
                got_last.push_back(bus.o_tx_last);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
            end
            if (bus.o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        bus.i_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        bus.i_fifo_empty = (fifo_q.size() == 0);
        bus.i_fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    end

    // Reference: LSB-first bytes of every word, zero-padded to the minimum length.
    function automatic void model_frame(input logic [31:0] w[$]);
        exp_data.delete();
        foreach (w[i])
            for (int b = 0; b < 4; b++) exp_data.push_back(8'(w[i] >> (8 * b)));
        while (exp_data.size() < MIN_BYTES) exp_data.push_back(8'h00);
    endfunction

    task automatic clear_capture();
        got_data.delete();
        got_last.delete();
        first_rd_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1;
        last_acc_cyc = -1; done_cyc = -1;
        done_cnt = 0; rd_cnt = 0; valid_cnt = 0; stab_err = 0; rd_empty_err = 0;
    endtask

    task automatic start_frame(input int cnt, output int sc);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_word_count = CNT_W'(cnt);
        sc = cyc;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        ok = (done_cnt > 0);
    endtask

    task automatic push_words(input logic [31:0] w[$]);
        @(posedge clk); #1;
        foreach (w[i]) fifo_q.push_back(w[i]);
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_word_count = '0;
        bus.i_fifo_empty = 1'b1; bus.i_fifo_data = '0; bus.i_tx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.o_busy, bus.o_done, bus.o_fifo_rd, bus.o_tx_valid, bus.o_tx_last, bus.o_tx_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b rd=%b valid=%b last=%b data=%h required all 0",
                     bus.o_busy, bus.o_done, bus.o_fifo_rd, bus.o_tx_valid, bus.o_tx_last, bus.o_tx_data);
        end
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy got %b required 0", bus.o_busy);
        end
    endtask

    task automatic test_full_frame();
        int sc, n;
        bit ok;
        clear_capture();
        t1_words.delete();
        for (int i = 0; i < 16; i++) t1_words.push_back($urandom);
        push_words(t1_words);
        start_frame(16, sc);
        wait_done(2000, ok);
        model_frame(t1_words);
        n = exp_data.size();
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_done_timeout no done seen"); end
        checks++;
        if (got_data.size() !== n) begin
            errors++; $display("FAIL t1_len got %0d required %0d", got_data.size(), n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL t1_byte[%0d] got %h/last=%0b required %h/last=%0b", i, got_data[i], got_last[i], exp_data[i], i == n - 1);
            end
        end
        checks++;
        if (first_rd_cyc !== sc + 1 || first_valid_cyc !== sc + 2) begin
            errors++;
            $display("FAIL t1_latency got rd@%0d valid@%0d required rd@%0d valid@%0d", first_rd_cyc, first_valid_cyc, sc + 1, sc + 2);
        end
        checks++;
        if (last_acc_cyc - first_acc_cyc + 1 !== n) begin
            errors++; $display("FAIL t1_bubbles got span %0d required %0d", last_acc_cyc - first_acc_cyc + 1, n);
        end
        checks++;
        if (done_cyc !== last_acc_cyc + IFG_CYCLES || done_cnt !== 1) begin
            errors++;
            $display("FAIL t1_ifg got done@%0d x%0d required done@%0d x1", done_cyc, done_cnt, last_acc_cyc + IFG_CYCLES);
        end
        checks++;
        if (rd_empty_err !== 0) begin errors++; $display("FAIL t1_rd_empty got %0d required 0", rd_empty_err); end
    endtask

    task automatic test_short_pad();
        int sc, n;
        bit ok;
        logic [31:0] w[$];
        clear_capture();
        w = '{32'h44332211, 32'h88776655};
        push_words(w);
        start_frame(2, sc);
        wait_done(2000, ok);
        model_frame(w);
        n = exp_data.size();
        checks++;
        if (!ok || got_data.size() !== n) begin
            errors++; $display("FAIL t2_len got %0d done=%0b required %0d", got_data.size(), ok, n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL t2_byte[%0d] got %h/last=%0b required %h/last=%0b", i, got_data[i], got_last[i], exp_data[i], i == n - 1);
            end
        end
        checks++;
        if (done_cyc !== last_acc_cyc + IFG_CYCLES) begin
            errors++; $display("FAIL t2_ifg got done@%0d required %0d", done_cyc, last_acc_cyc + IFG_CYCLES);
        end
    endtask

    task automatic test_backpressure();
        int sc, n;
        bit ok;
        clear_capture();
        push_words(t1_words);
        rdy_rand = 1'b1;
        start_frame(16, sc);
        wait_done(3000, ok);
        rdy_rand = 1'b0;
        model_frame(t1_words);
        n = exp_data.size();
        checks++;
        if (!ok || got_data.size() !== n) begin
            errors++; $display("FAIL t3_len got %0d done=%0b required %0d", got_data.size(), ok, n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL t3_byte[%0d] got %h/last=%0b required %h/last=%0b", i, got_data[i], got_last[i], exp_data[i], i == n - 1);
            end
        end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL t3_hold got %0d unstable cycles required 0", stab_err); end
    endtask

    task automatic test_fifo_underrun();
        int sc, n, k;
        bit ok;
        logic [31:0] w[$];
        logic [31:0] head[$];
        logic [31:0] tail[$];
        clear_capture();
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        for (int i = 0; i < 3; i++) head.push_back(w[i]);
        for (int i = 3; i < 8; i++) tail.push_back(w[i]);
        push_words(head);
        start_frame(8, sc);
        k = 0;
        while (fifo_q.size() != 0 && k < 200) begin @(posedge clk); k++; end
        repeat (5) @(posedge clk);
        push_words(tail);
        wait_done(2000, ok);
        model_frame(w);
        n = exp_data.size();
        checks++;
        if (!ok || got_data.size() !== n) begin
            errors++; $display("FAIL t4_len got %0d done=%0b required %0d", got_data.size(), ok, n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL t4_byte[%0d] got %h/last=%0b required %h/last=%0b", i, got_data[i], got_last[i], exp_data[i], i == n - 1);
            end
        end
        checks++;
        if (last_acc_cyc - first_acc_cyc + 1 <= n) begin
            errors++; $display("FAIL t4_stall got span %0d required more than %0d", last_acc_cyc - first_acc_cyc + 1, n);
        end
        checks++;
        if (rd_empty_err !== 0) begin errors++; $display("FAIL t4_rd_empty got %0d required 0", rd_empty_err); end
    endtask

    task automatic test_zero_and_busy();
        int sc, sc2;
        bit ok;
        logic [31:0] w[$];
        clear_capture();
        start_frame(0, sc);
        repeat (4) @(posedge clk);
        checks++;
        if (done_cyc !== sc + 1 || done_cnt !== 1 || rd_cnt !== 0 || valid_cnt !== 0) begin
            errors++;
            $display("FAIL t5_zero got done@%0d x%0d rd=%0d valid=%0d required done@%0d x1 rd=0 valid=0",
                     done_cyc, done_cnt, rd_cnt, valid_cnt, sc + 1);
        end
        clear_capture();
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        push_words(w);
        start_frame(2, sc);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL t5_busy got %b required 1", bus.o_busy); end
        start_frame(1, sc2);
        wait_done(2000, ok);
        repeat (40) @(posedge clk);
        checks++;
        if (!ok || done_cnt !== 1 || got_data.size() !== MIN_BYTES || fifo_q.size() !== 3) begin
            errors++;
            $display("FAIL t5_ignored got done x%0d bytes=%0d fifo_left=%0d required done x1 bytes=%0d fifo_left=3",
                     done_cnt, got_data.size(), fifo_q.size(), MIN_BYTES);
        end
        fifo_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int sc, k, n;
        bit ok;
        logic [31:0] w[$];
        clear_capture();
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        push_words(w);
        start_frame(16, sc);
        k = 0;
        while (got_data.size() < 10 && k < 500) begin @(posedge clk); k++; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_busy, bus.o_done, bus.o_fifo_rd, bus.o_tx_valid, bus.o_tx_last, bus.o_tx_data} !== 13'h0) begin
            errors++;
            $display("FAIL t6_async_reset got busy=%b done=%b rd=%b valid=%b last=%b data=%h required all 0",
                     bus.o_busy, bus.o_done, bus.o_fifo_rd, bus.o_tx_valid, bus.o_tx_last, bus.o_tx_data);
        end
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_capture();
        w.delete();
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        push_words(w);
        start_frame(2, sc);
        wait_done(2000, ok);
        model_frame(w);
        n = exp_data.size();
        checks++;
        if (!ok || got_data.size() !== n || done_cnt !== 1) begin
            errors++; $display("FAIL t6_len got %0d done x%0d required %0d done x1", got_data.size(), done_cnt, n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL t6_byte[%0d] got %h/last=%0b required %h/last=%0b", i, got_data[i], got_last[i], exp_data[i], i == n - 1);
            end
        end
    endtask

    initial begin
        clear_capture();
        test_reset();
        test_full_frame();
        test_short_pad();
        test_backpressure();
        test_fifo_underrun();
        test_zero_and_busy();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
